// File: rtl/pitch_pkg.sv
// Shared constants and FSM encoding for the period <-> pitch converters.
// Both directions consume these so the two maps stay exact inverses.
package pitch_pkg;
    localparam int PERIOD_W    = 14;
    localparam int PITCH_W     = 10;
    localparam int PERIOD_TOP  = 9088;
    localparam int PERIOD_MIN  = 568;
    localparam int OCTAVE_SPAN = 4544;
    localparam int INV_SLOPE   = 461;
    localparam int INV_SHIFT   = 13;
    localparam int NORM_STEPS  = 4;

    typedef enum logic [1:0] {
        IDLE,
        NORM,
        MULT,
        OUT
    } state_t;
endpackage

// File: rtl/sample_period_to_pitch_if.sv
// Strobe-in / pitch-out bundle; master drives strobes, slave (the converter) drives results.
interface sample_period_to_pitch_if #(
    parameter int PITCH_W = 10
);
    logic               sample_strobe_in;
    logic [PITCH_W-1:0] pitch_out;
    logic               pitch_valid_out;
    logic               out_of_range_out;
    logic               overrun_out;

    modport master (
        output sample_strobe_in,
        input  pitch_out, pitch_valid_out, out_of_range_out, overrun_out
    );

    modport slave (
        input  sample_strobe_in,
        output pitch_out, pitch_valid_out, out_of_range_out, overrun_out
    );
endinterface

// File: rtl/period_counter.sv
// Saturating strobe-to-strobe cycle counter; latches the period and pulses period_vld_out
// one cycle after an accepted strobe. The first strobe after reset only arms.
module period_counter
    import pitch_pkg::*;
#(
    parameter int CNT_W = PERIOD_W
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             strobe_in,
    input  logic             busy_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_vld_out
);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             armed_q, armed_d;
    logic             period_vld_q, period_vld_d;

    always_comb begin
        cnt_d        = cnt_q;
        armed_d      = armed_q | strobe_in;
        period_d     = period_q;
        period_vld_d = 1'b0;
        // Busy strobes still restart the count so the next period is measured from them.
        if (strobe_in) begin
            cnt_d = CNT_W'(1);
        end else if (cnt_q != '1) begin
            cnt_d = cnt_q + 1'b1;
        end
        if (strobe_in && armed_q && !busy_in) begin
            period_d     = cnt_q;
            period_vld_d = 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q        <= '0;
            armed_q      <= 1'b0;
            period_q     <= '0;
            period_vld_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            armed_q      <= armed_d;
            period_q     <= period_d;
            period_vld_q <= period_vld_d;
        end
    end

    assign period_out     = period_q;
    assign period_vld_out = period_vld_q;
endmodule

// File: rtl/sample_period_to_pitch.sv
// Converts measured strobe period to a 10-bit pitch code: octave normalise, then linear fraction.
// Fixed latency: pitch_valid_out 6 cycles after the strobe edge; strobes while busy pulse overrun_out.
module sample_period_to_pitch
    import pitch_pkg::*;
#(
    parameter int PERIOD_W = pitch_pkg::PERIOD_W,
    parameter int PITCH_W  = pitch_pkg::PITCH_W
) (
    input logic                     clk_in,
    input logic                     rst_n_in,
    sample_period_to_pitch_if.slave bus
);
    localparam logic [PERIOD_W:0]   TOP_PN    = (PERIOD_W+1)'(PERIOD_TOP);
    localparam logic [PERIOD_W:0]   SPAN_PN   = (PERIOD_W+1)'(OCTAVE_SPAN);
    localparam logic [PERIOD_W-1:0] TOP_P     = PERIOD_W'(PERIOD_TOP);
    localparam logic [PERIOD_W-1:0] MIN_P     = PERIOD_W'(PERIOD_MIN);
    localparam logic [1:0]          LAST_STEP = 2'(NORM_STEPS - 1);

    state_t               state_q, state_d;
    logic [PERIOD_W:0]    pn_q, pn_d;
    logic [2:0]           oct_q, oct_d;
    logic [1:0]           step_q, step_d;
    logic                 lo_q, lo_d, hi_q, hi_d;
    logic [PITCH_W-1:0]   pitch_q, pitch_d;
    logic                 vld_q, vld_d, oor_q, oor_d, ovr_q, ovr_d;

    logic [PERIOD_W-1:0]  period;
    logic                 period_vld;
    logic                 busy;
    logic [PERIOD_W-1:0]  diff;
    logic [22:0]          prod, frac_full;
    logic [7:0]           frac;
    logic [10:0]          raw;

    assign busy = (state_q != IDLE);

    period_counter #(.CNT_W(PERIOD_W)) u_period_counter (
        .clk_in         (clk_in),
        .rst_n_in       (rst_n_in),
        .strobe_in      (bus.sample_strobe_in),
        .busy_in        (busy),
        .period_out     (period),
        .period_vld_out (period_vld)
    );

    // Pn sits in [4544, 9088] after normalising (for in-range P), so the fraction spans one octave.
    always_comb begin
        diff      = (pn_q > TOP_PN) ? '0 : PERIOD_W'(TOP_PN - pn_q);
        prod      = 23'(diff) * 23'(INV_SLOPE);
        frac_full = prod >> INV_SHIFT;
        frac      = (frac_full > 23'd255) ? 8'hFF : frac_full[7:0];
        raw       = {oct_q, frac};
    end

    always_comb begin
        state_d = state_q;
        pn_d    = pn_q;
        oct_d   = oct_q;
        step_d  = step_q;
        lo_d    = lo_q;
        hi_d    = hi_q;
        pitch_d = pitch_q;
        vld_d   = 1'b0;
        oor_d   = oor_q;
        ovr_d   = bus.sample_strobe_in && busy;
        case (state_q)
            IDLE: begin
                if (period_vld) begin
                    pn_d    = {1'b0, period};
                    oct_d   = '0;
                    step_d  = '0;
                    lo_d    = (period < MIN_P);
                    hi_d    = (period > TOP_P);
                    state_d = NORM;
                end
            end
            NORM: begin
                if (pn_q <= SPAN_PN && pn_q != '0) begin
                    pn_d  = pn_q << 1;
                    oct_d = oct_q + 3'd1;
                end
                step_d = step_q + 2'd1;
                if (step_q == LAST_STEP) begin
                    state_d = MULT;
                end
            end
            MULT: begin
                if (hi_q) begin
                    pitch_d = '0;
                end else if (lo_q || raw > 11'd1023) begin
                    pitch_d = '1;
                end else begin
                    pitch_d = raw[PITCH_W-1:0];
                end
                oor_d   = hi_q | lo_q;
                vld_d   = 1'b1;
                state_d = OUT;
            end
            OUT: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
            pn_q    <= '0;
            oct_q   <= '0;
            step_q  <= '0;
            lo_q    <= 1'b0;
            hi_q    <= 1'b0;
            pitch_q <= '0;
            vld_q   <= 1'b0;
            oor_q   <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pn_q    <= pn_d;
            oct_q   <= oct_d;
            step_q  <= step_d;
            lo_q    <= lo_d;
            hi_q    <= hi_d;
            pitch_q <= pitch_d;
            vld_q   <= vld_d;
            oor_q   <= oor_d;
            ovr_q   <= ovr_d;
        end
    end

    assign bus.pitch_out        = pitch_q;
    assign bus.pitch_valid_out  = vld_q;
    assign bus.out_of_range_out = oor_q;
    assign bus.overrun_out      = ovr_q;
endmodule

// File: tb/tb_sample_period_to_pitch.sv
// Directed bench for sample_period_to_pitch: periods with hand-derived pitch codes,
// arming, saturation, overrun and asynchronous reset mid-conversion.
module tb_sample_period_to_pitch;
    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    sample_period_to_pitch_if #(.PITCH_W(10)) bus ();

    sample_period_to_pitch dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called at a negedge; the strobe is sampled on the next posedge, returns at the following negedge.
    task automatic fire();
        bus.sample_strobe_in = 1'b1;
        @(negedge clk);
        bus.sample_strobe_in = 1'b0;
    endtask

    task automatic wait_valid(input int bound, output int lat, output bit found);
        found = 1'b0;
        lat   = bound;
        for (int i = 1; i <= bound; i++) begin
            @(negedge clk);
            if (bus.pitch_valid_out === 1'b1) begin
                lat   = i;
                found = 1'b1;
                return;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.sample_strobe_in = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (bus.pitch_out !== 10'd0) begin errors++; $display("FAIL reset_pitch got %0d want 0", bus.pitch_out); end
        checks++; if (bus.pitch_valid_out !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", bus.pitch_valid_out); end
        checks++; if (bus.out_of_range_out !== 1'b0) begin errors++; $display("FAIL reset_oor got %b want 0", bus.out_of_range_out); end
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", bus.overrun_out); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_top_period();
        int lat;
        bit found;
        fire();
        wait_valid(8, lat, found);
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL arm_only got valid at %0d want none", lat); end
        for (int k = 0; k < 3; k++) begin
            repeat (9088 - 1 - lat) @(negedge clk);
            fire();
            wait_valid(8, lat, found);
            checks++; if (found !== 1'b1 || lat != 6) begin errors++; $display("FAIL top_latency[%0d] got found=%0d lat=%0d want lat=6", k, found, lat); end
            checks++; if (bus.pitch_out !== 10'd0) begin errors++; $display("FAIL top_pitch[%0d] got %0d want 0", k, bus.pitch_out); end
            checks++; if (bus.out_of_range_out !== 1'b0) begin errors++; $display("FAIL top_oor[%0d] got %b want 0", k, bus.out_of_range_out); end
            @(negedge clk);
            lat++;
            checks++; if (bus.pitch_valid_out !== 1'b0) begin errors++; $display("FAIL top_pulse[%0d] valid got %b want 0", k, bus.pitch_valid_out); end
        end
    endtask

    task automatic test_saturation();
        int lat;
        bit found;
        fire();
        wait_valid(8, lat, found);
        repeat (17000) @(negedge clk);
        fire();
        wait_valid(8, lat, found);
        checks++; if (found !== 1'b1 || lat != 6) begin errors++; $display("FAIL sat_latency got found=%0d lat=%0d want lat=6", found, lat); end
        checks++; if (bus.pitch_out !== 10'd0) begin errors++; $display("FAIL sat_pitch got %0d want 0", bus.pitch_out); end
        checks++; if (bus.out_of_range_out !== 1'b1) begin errors++; $display("FAIL sat_oor got %b want 1", bus.out_of_range_out); end
    endtask

    task automatic test_periods();
        int        lat;
        bit        found;
        int        per_tab [7] = '{4544, 6816, 1136, 600, 10000, 568, 500};
        bit [9:0]  pit_tab [7] = '{10'd256, 10'd127, 10'd768, 10'd1009, 10'd0, 10'd1023, 10'd1023};
        bit        oor_tab [7] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        fire();
        wait_valid(8, lat, found);
        for (int k = 0; k < 7; k++) begin
            repeat (per_tab[k] - 1 - lat) @(negedge clk);
            fire();
            wait_valid(8, lat, found);
            checks++; if (found !== 1'b1 || lat != 6) begin errors++; $display("FAIL per%0d_latency got found=%0d lat=%0d want lat=6", per_tab[k], found, lat); end
            checks++; if (bus.pitch_out !== pit_tab[k]) begin errors++; $display("FAIL per%0d_pitch got %0d want %0d", per_tab[k], bus.pitch_out, pit_tab[k]); end
            checks++; if (bus.out_of_range_out !== oor_tab[k]) begin errors++; $display("FAIL per%0d_oor got %b want %b", per_tab[k], bus.out_of_range_out, oor_tab[k]); end
        end
    endtask

    task automatic test_reset_mid();
        int lat;
        bit found;
        repeat (20) @(negedge clk);
        fire();
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        checks++; if (bus.pitch_out !== 10'd0) begin errors++; $display("FAIL midrst_pitch got %0d want 0", bus.pitch_out); end
        checks++; if (bus.out_of_range_out !== 1'b0) begin errors++; $display("FAIL midrst_oor got %b want 0", bus.out_of_range_out); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        wait_valid(10, lat, found);
        checks++; if (found !== 1'b0) begin errors++; $display("FAIL midrst_valid got valid at %0d want none", lat); end
    endtask

    task automatic test_overrun();
        int lat;
        bit found;
        fire();
        repeat (2) @(negedge clk);
        fire();
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_first got %b want 0", bus.overrun_out); end
        repeat (2) @(negedge clk);
        fire();
        checks++; if (bus.overrun_out !== 1'b1) begin errors++; $display("FAIL ovr_pulse got %b want 1", bus.overrun_out); end
        @(negedge clk);
        checks++; if (bus.overrun_out !== 1'b0) begin errors++; $display("FAIL ovr_single got %b want 0", bus.overrun_out); end
        wait_valid(8, lat, found);
        checks++; if (found !== 1'b1 || lat != 2) begin errors++; $display("FAIL ovr_latency got found=%0d lat=%0d want lat=2", found, lat); end
        checks++; if (bus.pitch_out !== 10'd1023) begin errors++; $display("FAIL ovr_pitch got %0d want 1023", bus.pitch_out); end
        checks++; if (bus.out_of_range_out !== 1'b1) begin errors++; $display("FAIL ovr_oor got %b want 1", bus.out_of_range_out); end
        // Period 1000 from the dropped strobe gives 829; measured from the accepted one it would be 827.
        repeat (1000 - 1 - 1 - lat) @(negedge clk);
        fire();
        wait_valid(8, lat, found);
        checks++; if (found !== 1'b1 || lat != 6) begin errors++; $display("FAIL after_ovr_latency got found=%0d lat=%0d want lat=6", found, lat); end
        checks++; if (bus.pitch_out !== 10'd829) begin errors++; $display("FAIL after_ovr_pitch got %0d want 829", bus.pitch_out); end
        checks++; if (bus.out_of_range_out !== 1'b0) begin errors++; $display("FAIL after_ovr_oor got %b want 0", bus.out_of_range_out); end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.sample_strobe_in = 1'b0;
        test_reset();
        test_top_period();
        test_saturation();
        test_periods();
        test_reset_mid();
        test_overrun();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
